// File: rtl/axi_read_slave_mem.sv
// rtl/axi_read_slave_mem.sv - AXI4 read-only slave over a word-addressed memory
// FIXED/INCR/WRAP bursts, per-beat SLVERR, backdoor preload port.
module axi_read_slave_mem #(
   parameter int ID_W      = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 256
) (
   input  logic                         ACLK,
   input  logic                         ARESETn,
   input  logic [ID_W-1:0]              ARID,
   input  logic [ADDR_W-1:0]            ARADDR,
   input  logic [2:0]                   ARSIZE,
   input  logic [3:0]                   ARLEN,
   input  logic [1:0]                   ARBURST,
   input  logic                         ARVALID,
   output logic                         ARREADY,
   output logic [ID_W-1:0]              RID,
   output logic [DATA_W-1:0]            RDATA,
   output logic [1:0]                   RRESP,
   output logic                         RLAST,
   output logic                         RVALID,
   input  logic                         RREADY,
   input  logic                         mem_we,
   input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
   input  logic [DATA_W-1:0]            mem_wdata
);

   localparam int NB  = DATA_W / 8;
   localparam int NBL = $clog2(NB);
   localparam int MW  = $clog2(MEM_DEPTH);
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t              state_q, state_d;
   logic                arready_q, arready_d;
   logic                rvalid_q, rvalid_d;
   logic                rlast_q, rlast_d;
   logic [ID_W-1:0]     rid_q, rid_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [2:0]          size_q, size_d;
   logic [3:0]          len_q, len_d;
   logic [1:0]          burst_q, burst_d;
   logic                berr_q, berr_d;

   logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

   logic [ADDR_W-1:0]   f_addr;
   logic                f_berr;
   logic                f_oor;
   logic [MW-1:0]       f_idx;
   logic                beat_err;
   logic [DATA_W-1:0]   beat_data;
   logic [1:0]          beat_resp;

   // Nonblocking write gives read-before-write against a same-edge beat fetch.
   always_ff @(posedge ACLK) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   function automatic logic [ADDR_W-1:0] next_addr(
      input logic [ADDR_W-1:0] a,
      input logic [2:0]        size,
      input logic [3:0]        len,
      input logic [1:0]        burst
   );
      logic [ADDR_W-1:0] step;
      logic [ADDR_W-1:0] wlen;
      step = ONE << size;
      wlen = (ADDR_W'(len) + ONE) << size;
      case (burst)
         2'b00:   next_addr = a;
         2'b10:   next_addr = (a & ~(wlen - ONE)) | ((a + step) & (wlen - ONE));
         default: next_addr = (a & ~(step - ONE)) + step;
      endcase
   endfunction

   function automatic logic burst_error(
      input logic [ADDR_W-1:0] a,
      input logic [2:0]        size,
      input logic [3:0]        len,
      input logic [1:0]        burst
   );
      logic [ADDR_W-1:0] step;
      logic              err;
      step = ONE << size;
      err  = 1'b0;
      if (int'(size) > NBL) err = 1'b1;
      if (burst == 2'b11) err = 1'b1;
      if (burst == 2'b10) begin
         if (!(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) err = 1'b1;
         if ((a & (step - ONE)) != '0) err = 1'b1;
      end
      burst_error = err;
   endfunction

   always_comb begin
      state_d   = state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rid_d     = rid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      size_d    = size_q;
      len_d     = len_q;
      burst_d   = burst_q;
      berr_d    = berr_q;

      // Beat 0 is fetched straight from the AR inputs; later beats from addr_q.
      f_addr    = (state_q == S_IDLE) ? ARADDR : addr_q;
      f_berr    = (state_q == S_IDLE) ? burst_error(ARADDR, ARSIZE, ARLEN, ARBURST) : berr_q;
      f_oor     = (f_addr >> (NBL + MW)) != '0;
      f_idx     = f_addr[NBL+MW-1:NBL];
      beat_err  = f_berr | f_oor;
      beat_data = beat_err ? '0 : mem_q[f_idx];
      beat_resp = beat_err ? 2'b10 : 2'b00;

      case (state_q)
         S_IDLE: begin
            arready_d = 1'b1;
            if (ARVALID && arready_q) begin
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rlast_d   = (ARLEN == 4'd0);
               rid_d     = ARID;
               rdata_d   = beat_data;
               rresp_d   = beat_resp;
               cnt_d     = 4'd0;
               addr_d    = next_addr(ARADDR, ARSIZE, ARLEN, ARBURST);
               size_d    = ARSIZE;
               len_d     = ARLEN;
               burst_d   = ARBURST;
               berr_d    = f_berr;
               state_d   = S_BURST;
            end
         end
         S_BURST: begin
            if (RREADY) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  cnt_d   = cnt_q + 4'd1;
                  rlast_d = ((cnt_q + 4'd1) == len_q);
                  rdata_d = beat_data;
                  rresp_d = beat_resp;
                  addr_d  = next_addr(addr_q, size_q, len_q, burst_q);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q   <= S_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
         cnt_q     <= 4'd0;
         addr_q    <= '0;
         size_q    <= 3'd0;
         len_q     <= 4'd0;
         burst_q   <= 2'b00;
         berr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         len_q     <= len_d;
         burst_q   <= burst_d;
         berr_q    <= berr_d;
      end
   end

   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RLAST   = rlast_q;
   assign RID     = rid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_read_slave_mem.sv
// tb/tb_axi_read_slave_mem.sv - self-checking bench for axi_read_slave_mem
module tb_axi_read_slave_mem;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic [3:0]  ARID;
   logic [31:0] ARADDR;
   logic [2:0]  ARSIZE;
   logic [3:0]  ARLEN;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY;
   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;
   logic        mem_we;
   logic [7:0]  mem_waddr;
   logic [31:0] mem_wdata;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] model_mem [256];
   logic [31:0] exp_data  [16];
   logic [1:0]  exp_resp  [16];

   axi_read_slave_mem #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .ARID(ARID), .ARADDR(ARADDR), .ARSIZE(ARSIZE), .ARLEN(ARLEN), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected beats from the address/response rules, using plain integer arithmetic.
   task automatic model_burst(input logic [31:0] addr, input int size, input int len, input int burst);
      int unsigned a, step, wbytes, base;
      bit berr, oor;
      a    = addr;
      step = 32'd1 << size;
      berr = (size > 2) || (burst == 3) ||
             (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
             (burst == 2 && (a % step) != 0);
      for (int b = 0; b <= len; b++) begin
         oor = (a / 4) >= 256;
         if (berr || oor) begin
            exp_data[b] = 32'h0;
            exp_resp[b] = 2'b10;
         end else begin
            exp_data[b] = model_mem[a / 4];
            exp_resp[b] = 2'b00;
         end
         if (burst == 1 || burst == 3) begin
            a = (a / step) * step + step;
         end else if (burst == 2) begin
            wbytes = (len + 1) * step;
            base   = (a / wbytes) * wbytes;
            a      = base + ((a + step) % wbytes);
         end
      end
   endtask

   // rmode: 0 always ready, 1 one pulse every 3 cycles, 2 random.
   task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size,
                            input logic [3:0] len, input logic [1:0] burst, input int rmode,
                            input int bd_beat, input int abort_after);
      int t, b, cyc;
      bit rdy;
      model_burst(addr, int'(size), int'(len), int'(burst));
      @(negedge ACLK);
      ARID = id; ARADDR = addr; ARSIZE = size; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
      t = 0;
      while (ARREADY !== 1'b1 && t < 50) begin
         @(negedge ACLK);
         t++;
      end
      if (ARREADY !== 1'b1) begin
         check("ar_handshake_timeout", 32'(ARREADY), 32'd1);
         ARVALID = 1'b0;
         return;
      end
      @(negedge ACLK);
      ARVALID = 1'b0;
      check("rvalid_after_ar", 32'(RVALID), 32'd1);
      check("arready_busy", 32'(ARREADY), 32'd0);
      b = 0;
      cyc = 0;
      while (b <= int'(len) && cyc < 200) begin
         check($sformatf("beat%0d_rvalid", b), 32'(RVALID), 32'd1);
         if (RVALID !== 1'b1) break;
         check($sformatf("beat%0d_rid", b), 32'(RID), 32'(id));
         check($sformatf("beat%0d_rdata", b), RDATA, exp_data[b]);
         check($sformatf("beat%0d_rresp", b), 32'(RRESP), 32'(exp_resp[b]));
         check($sformatf("beat%0d_rlast", b), 32'(RLAST), 32'(b == int'(len)));
         rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
         RREADY = rdy;
         if (rdy) begin
            if (b == bd_beat) begin
               mem_we = 1'b1; mem_waddr = 8'd4; mem_wdata = 32'hDEAD_BEEF;
            end
            b++;
         end
         cyc++;
         @(negedge ACLK);
         RREADY = 1'b0;
         mem_we = 1'b0;
         if (abort_after >= 0 && b == abort_after + 1) begin
            ARESETn = 1'b0;
            @(negedge ACLK);
            ARESETn = 1'b1;
            check("abort_rvalid", 32'(RVALID), 32'd0);
            check("abort_rlast", 32'(RLAST), 32'd0);
            @(negedge ACLK);
            check("abort_arready", 32'(ARREADY), 32'd1);
            check("abort_rvalid_idle", 32'(RVALID), 32'd0);
            return;
         end
      end
      check("beat_count", 32'(b), 32'(int'(len) + 1));
      check("end_rvalid", 32'(RVALID), 32'd0);
      check("end_arready", 32'(ARREADY), 32'd1);
   endtask

   initial begin
      logic [31:0] ra;
      logic [2:0]  rs;
      logic [3:0]  rl;
      logic [1:0]  rb;
      ARESETn = 1'b0; ARID = '0; ARADDR = '0; ARSIZE = '0; ARLEN = '0; ARBURST = '0;
      ARVALID = 1'b0; RREADY = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;

      repeat (3) @(negedge ACLK);
      check("rst_arready", 32'(ARREADY), 32'd0);
      check("rst_rvalid", 32'(RVALID), 32'd0);
      check("rst_rlast", 32'(RLAST), 32'd0);
      check("rst_rid", 32'(RID), 32'd0);
      check("rst_rdata", RDATA, 32'd0);
      check("rst_rresp", 32'(RRESP), 32'd0);

      for (int i = 0; i < 256; i++) begin
         mem_we = 1'b1; mem_waddr = 8'(i); mem_wdata = 32'hA000_0000 + 32'(i);
         model_mem[i] = 32'hA000_0000 + 32'(i);
         @(negedge ACLK);
      end
      mem_we = 1'b0;

      ARESETn = 1'b1;
      check("pre_release_arready", 32'(ARREADY), 32'd0);
      @(negedge ACLK);
      check("release_arready", 32'(ARREADY), 32'd1);

      run_burst(4'd5, 32'h10,  3'd2, 4'd3, 2'b01, 0, -1, -1);
      run_burst(4'd2, 32'h38,  3'd2, 4'd3, 2'b10, 0, -1, -1);
      run_burst(4'd3, 32'h20,  3'd2, 4'd2, 2'b00, 0, -1, -1);
      run_burst(4'd7, 32'h40,  3'd2, 4'd7, 2'b01, 1, -1, -1);
      run_burst(4'd1, 32'h10,  3'd3, 4'd3, 2'b01, 0, -1, -1);
      run_burst(4'd4, 32'h3F8, 3'd2, 4'd3, 2'b01, 0, -1, -1);
      run_burst(4'd6, 32'h40,  3'd2, 4'd2, 2'b10, 0, -1, -1);
      run_burst(4'd8, 32'h80,  3'd2, 4'd3, 2'b11, 2, -1, -1);
      run_burst(4'd9, 32'h0,   3'd2, 4'd7, 2'b01, 0, -1, 2);
      run_burst(4'hA, 32'h0,   3'd2, 4'd0, 2'b01, 0, -1, -1);
      run_burst(4'hB, 32'h0C,  3'd2, 4'd1, 2'b01, 0, 0, -1);
      model_mem[4] = 32'hDEAD_BEEF;
      run_burst(4'hC, 32'h10,  3'd2, 4'd0, 2'b01, 0, -1, -1);

      for (int k = 0; k < 25; k++) begin
         ra = 32'($urandom_range(0, 32'h47F));
         rs = 3'($urandom_range(0, 3));
         rl = 4'($urandom_range(0, 15));
         rb = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) ra = ra & ~((32'd1 << rs) - 32'd1);
         if (rb == 2'b10 && $urandom_range(0, 2) != 0) rl = 4'((2 << $urandom_range(0, 3)) - 1);
         run_burst(4'($urandom_range(0, 15)), ra, rs, rl, rb, 2, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
